// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port general-purpose register file. Operands are read in ID and
//   results are written back from WB. Two write ports (port 1 wins on an
//   address collision), a per-register busy scoreboard for the hazard unit,
//   and a software-triggered clear sweep that zeroes one register per cycle.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   NREAD    number of read ports (1..4)
//   ZERO_REG 1: register 0 always reads 0, ignores writes and alloc
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   raddr / rdata      packed read addresses / data, port k at slice k
//   rbusy              busy flag of each read address
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (priority over port 0)
//   alloc_en/addr      mark a destination register busy
//   clr_req            pulse to start the clear sweep
//   ready              high while idle, low during the sweep
//
// Build option
//   REGFILE_MP_BYPASS_EN  when defined, write data is forwarded to read ports
//                         in the same cycle (port 1 over port 0).
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    alloc_en,
  input  logic [ADDR_W-1:0]       alloc_addr,
  input  logic                    clr_req,
  output logic                    ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t            state;
  logic              ready_r;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] sweep_addr;
  logic              idle;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wr0_ok;
  logic wr1_ok;
  logic alloc_ok;

  // Register 0 is hard-wired when ZERO_REG is set.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign idle       = (state == ST_IDLE);
  assign sweep_addr = cnt[ADDR_W-1:0];
  // Carry into the extra counter bit marks the last register of the sweep.
  assign cnt_inc    = cnt + 1'b1;

  assign wr0_ok   = idle && we0      && addr_ok(waddr0);
  assign wr1_ok   = idle && we1      && addr_ok(waddr1);
  assign alloc_ok = idle && alloc_en && addr_ok(alloc_addr);

  assign ready = ready_r;

  // Clear-sweep control
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_SWEEP;
            cnt     <= '0;
            ready_r <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (cnt_inc[ADDR_W]) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_r <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Register array: sweep clears override all traffic, port 1 beats port 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (!idle) begin
        if (sweep_addr == ADDR_W'(i)) begin
          regs[i] <= '0;
        end
      end else if (wr1_ok && (waddr1 == ADDR_W'(i))) begin
        regs[i] <= wdata1;
      end else if (wr0_ok && (waddr0 == ADDR_W'(i))) begin
        regs[i] <= wdata0;
      end
    end
  end

  // Busy scoreboard: a same-cycle alloc outranks the clearing write
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        busy[i] <= 1'b0;
      end else if (!idle) begin
        if (sweep_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end else if (alloc_ok && (alloc_addr == ADDR_W'(i))) begin
        busy[i] <= 1'b1;
      end else if ((wr1_ok && (waddr1 == ADDR_W'(i))) ||
                   (wr0_ok && (waddr0 == ADDR_W'(i)))) begin
        busy[i] <= 1'b0;
      end
    end
  end

  // Read ports
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs[ra];
      rb = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
      // A forwarded value is already resolved, so it only looks busy if a
      // new owner is allocated in this same cycle.
      if (wr1_ok && (ra == waddr1)) begin
        rd = wdata1;
        rb = alloc_ok && (alloc_addr == ra);
      end else if (wr0_ok && (ra == waddr0)) begin
        rd = wdata0;
        rb = alloc_ok && (alloc_addr == ra);
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
    assign rbusy[k]                  = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    we0, we1;
  logic [ADDR_W-1:0]       waddr0, waddr1;
  logic [DATA_W-1:0]       wdata0, wdata1;
  logic                    alloc_en;
  logic [ADDR_W-1:0]       alloc_addr;
  logic                    clr_req;
  logic                    ready;

  logic [ADDR_W-1:0] raddr0, raddr1;
  logic [DATA_W-1:0] rd0, rd1;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  assign raddr = {raddr1, raddr0};
  assign rd0   = rdata[DATA_W-1:0];
  assign rd1   = rdata[2*DATA_W-1:DATA_W];

  regfile_mp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NREAD   (NREAD),
    .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .clr_req   (clr_req),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; raddr0 = '0; raddr1 = '0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0;

    // reset
    tick; tick;
    rst = 1'b0;
    raddr0 = 5'd3; raddr1 = 5'd0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_rbusy", {30'd0, rbusy}, 32'd0);

    // reset then write
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
    tick;
    we0 = 1'b0;
    #1;
    chk("wr_rd0", rd0, 32'hDEADBEEF);
    chk("wr_rd1_zero", rd1, 32'h0);

    // write conflict: port 1 wins
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick;
    we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd7;
    #1;
    chk("conflict_p1", rd0, 32'h22);

    // writes to register 0 are ignored
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h55;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h66;
    tick;
    we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd0;
    #1;
    chk("zero_reg", rd0, 32'h0);

    // scoreboard
    alloc_en = 1'b1; alloc_addr = 5'd5; raddr0 = 5'd5;
    tick;
    alloc_en = 1'b0;
    #1;
    chk("alloc_busy", {31'd0, rbusy[0]}, 32'd1);
    alloc_en = 1'b1; alloc_addr = 5'd5;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
    tick;
    alloc_en = 1'b0; we0 = 1'b0;
    #1;
    chk("alloc_wr_busy", {31'd0, rbusy[0]}, 32'd1);
    chk("alloc_wr_data", rd0, 32'h1234);
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h5678;
    tick;
    we1 = 1'b0;
    #1;
    chk("wr_clears_busy", {31'd0, rbusy[0]}, 32'd0);
    chk("wr_clears_data", rd0, 32'h5678);
    alloc_en = 1'b1; alloc_addr = 5'd0; raddr0 = 5'd0;
    tick;
    alloc_en = 1'b0;
    #1;
    chk("alloc_zero", {31'd0, rbusy[0]}, 32'd0);

    // same-cycle visibility of a write
    raddr0 = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass_same", rd0, 32'hA5A5A5A5);
`else
    chk("nobypass_same", rd0, 32'h0);
`endif
    chk("bypass_busy", {31'd0, rbusy[0]}, 32'd0);
    tick;
    we1 = 1'b0;
    #1;
    chk("bypass_next", rd0, 32'hA5A5A5A5);

    // fill everything, mark one register busy
    for (int a = 1; a < 32; a++) begin
      we0 = 1'b1; waddr0 = ADDR_W'(a); wdata0 = 32'hFFFFFFFF;
      tick;
    end
    we0 = 1'b0;
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick;
    alloc_en = 1'b0;
    raddr0 = 5'd31; raddr1 = 5'd12;
    #1;
    chk("fill_31", rd0, 32'hFFFFFFFF);
    chk("fill_busy12", {31'd0, rbusy[1]}, 32'd1);

    // clear sweep
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    chk("sweep_ready_lo", {31'd0, ready}, 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        raddr0 = 5'd31;
        #1;
        chk("sweep_read_live", rd0, 32'hFFFFFFFF);
      end
      if (n == 10) begin
        we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h77;
        alloc_en = 1'b1; alloc_addr = 5'd2;
      end else begin
        we0 = 1'b0; alloc_en = 1'b0;
      end
      clr_req = (n == 20);
      tick;
    end
    we0 = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    chk("sweep_len", n, 32);
    for (int a = 0; a < 32; a++) begin
      raddr0 = ADDR_W'(a);
      #1;
      chk($sformatf("swept_r%0d", a), rd0, 32'h0);
      chk($sformatf("swept_b%0d", a), {31'd0, rbusy[0]}, 32'd0);
    end
    tick;
    chk("sweep_ready_hi", {31'd0, ready}, 32'd1);

    // reset in the middle of a sweep
    we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hAAAA0020;
    tick;
    waddr0 = 5'd30; wdata0 = 32'h00003030;
    alloc_en = 1'b1; alloc_addr = 5'd25;
    tick;
    we0 = 1'b0; alloc_en = 1'b0;
    raddr0 = 5'd20; raddr1 = 5'd25;
    #1;
    chk("pre_mid_data", rd0, 32'hAAAA0020);
    chk("pre_mid_busy", {31'd0, rbusy[1]}, 32'd1);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_r20", rd0, 32'h0);
    chk("mid_rst_b25", {31'd0, rbusy[1]}, 32'd0);
    raddr0 = 5'd30;
    #1;
    chk("mid_rst_r30", rd0, 32'h0);
    tick;
    chk("mid_rst_idle", {31'd0, ready}, 32'd1);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99;
    raddr0 = 5'd4;
    tick;
    we0 = 1'b0;
    #1;
    chk("post_rst_wr", rd0, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, two-read pipeline register bank.
- Read in ID, written from WB; adds a second write port, same-cycle write-through, per-register busy scoreboard, and a sequential software-triggered clear sweep.
- Feeds the hazard unit (busy flags) and the ID operand muxes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes/alloc.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- raddr  in  NREAD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  packed read data, same packing.
- rbusy  out  NREAD  busy flag of each read address.
- we0, we1  in  1  write enables, port 0 and port 1.
- waddr0, waddr1  in  ADDR_W  write addresses.
- wdata0, wdata1  in  DATA_W  write data.
- alloc_en  in  1  mark alloc_addr busy (destination allocated in ID).
- alloc_addr  in  ADDR_W  register to mark busy.
- clr_req  in  1  start clear sweep (one-cycle pulse; level ignored while sweeping).
- ready  out  1  high when IDLE; low during sweep.

Behaviour:
- Reset (sync, rst=1 at clk edge): all registers 0, all busy bits 0, FSM IDLE, sweep counter 0.
  - Outputs after reset: ready=1; rdata=0; rbusy=0.
  - rst has priority over every other input, including mid-sweep.
- Reads: combinational from the current array.
  - Address 0 with ZERO_REG=1 gives rdata=0 and rbusy=0.
- Writes: committed at the clk edge when weN=1, FSM IDLE, and the address is nonzero (or ZERO_REG=0).
  - we0 and we1 to the same address: port 1 wins (younger instruction).
  - A write clears the busy bit of its address.
- Alloc: alloc_en sets busy[alloc_addr] at the edge; ignored for address 0 when ZERO_REG=1.
  - Alloc and write to the same address in the same cycle: busy ends 1 (alloc wins), data still written.
- Clear FSM, states IDLE and SWEEP:
  - IDLE + clr_req: go to SWEEP, counter=0, ready=0 from the next cycle.
  - SWEEP: each cycle writes reg[counter]=0, busy[counter]=0, counter+1.
  - After address 2**ADDR_W-1 is cleared, return to IDLE; ready=1 the following cycle.
  - Sweep length is exactly 2**ADDR_W cycles; the counter wraps to 0 on exit.
  - During SWEEP: we0/we1/alloc_en are ignored (dropped, not queued), clr_req is ignored, reads still return current array contents.
- Widths: no arithmetic on data; the counter is ADDR_W+1 bits wide so it can detect terminal count.

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-through forwarding.
  - When weN=1 in IDLE and raddr[k]==waddrN (nonzero when ZERO_REG=1), rdata[k]=wdataN combinationally, port 1 over port 0.
  - rbusy[k] reads 0 for a forwarded address unless alloc_en targets it in the same cycle.
- Undefined: reads return stored values only; the new data is visible the cycle after the write edge.

Test Plan:
- Reset then write: rst 1 cycle, we0=1 waddr0=3 wdata0=0xDEADBEEF → next cycle raddr0=3 gives 0xDEADBEEF; raddr1=0 gives 0.
- Write conflict: we0 and we1 both to addr 7, data 0x11 and 0x22 → reg7=0x22; write to addr 0 → still reads 0.
- Scoreboard: alloc_en addr 5 → rbusy=1 next cycle; same cycle as a write to 5 → rbusy stays 1; a later write alone → rbusy=0.
- Sweep: fill all regs with 0xFFFFFFFF, pulse clr_req → ready=0 for 32 cycles; writes during the sweep are dropped; ready=1 afterwards and all regs read 0.
- Reset mid-sweep: rst at sweep cycle 10 → ready=1 next cycle, all regs 0, FSM IDLE.
- Bypass (macro defined): we1 addr 9 data 0xA5A5A5A5 with raddr0=9 in the same cycle → rdata0=0xA5A5A5A5 in that cycle. Macro undefined → old value in that cycle, new value the next cycle.
